// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the fetch stage: opcodes it predecodes, the bubble
// encoding handed to decode, and the fetch FSM state encodings.
package inst_fetch_pkg;

  localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;

  // Decode treats an all-zero instruction word as "no instruction".
  localparam logic [31:0] FE_BUBBLE_IR  = 32'h0000_0000;

  localparam logic [1:0]  ST_REQ  = 2'd0;
  localparam logic [1:0]  ST_RSP  = 2'd1;
  localparam logic [1:0]  ST_HOLD = 2'd2;

  // Instruction memory is word addressed; the low two bits never reach it.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/inst_fetch_predecode.sv
// Combinational predecode of a fetched word: spots branches and JAL and
// produces the statically predicted next fetch address.
module fe_predecode
  import inst_fetch_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [31:0] pc_i,
  output logic        is_branch_o,
  output logic        is_jal_o,
  output logic        pred_taken_o,
  output logic [31:0] next_pc_o
);

  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic [31:0] sum;

  // Backward branches are predicted taken, JAL always follows its offset.
  always_comb begin
    is_branch_o  = (word_i[6:0] == OPCODE_BRANCH);
    is_jal_o     = (word_i[6:0] == OPCODE_JAL);
    b_imm        = {{20{word_i[31]}}, word_i[7], word_i[30:25], word_i[11:8], 1'b0};
    j_imm        = {{12{word_i[31]}}, word_i[19:12], word_i[20], word_i[30:21], 1'b0};
    pred_taken_o = is_branch_o & word_i[31];
    if (pred_taken_o) begin
      sum = pc_i + b_imm;
    end else if (is_jal_o) begin
      sum = pc_i + j_imm;
    end else begin
      sum = pc_i + 32'd4;
    end
    next_pc_o = word_align(sum);
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the PC, keeps at most one instruction-memory read in
// flight, predicts statically and feeds the fe2de registers used by decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        de_stall,
  input  logic        branch_predict_err,
  input  logic [31:0] de2fe_branch_target,
  input  logic        ex2fe_redirect,
  input  logic [31:0] ex2fe_target,
  output logic [31:0] fe2de_pc_ffout,
  output logic [31:0] fe2de_ir_ffout,
  output logic        fe2de_predict_bxxtaken_ffout,
  output logic        fe2de_rv16_ffout
);

  logic [1:0]  state_q, state_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic        drop_q, drop_d;
  logic        owed_q;
  logic        hold_v_q, hold_v_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_ir_q, hold_ir_d;
  logic        hold_pred_q, hold_pred_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        pred_q, pred_d;

  logic        pd_is_branch, pd_is_jal, pd_taken;
  logic [31:0] pd_next_pc;
  logic        redir, drop_eff, rsp_ok, to_fe;
  logic [31:0] redir_pc;
  logic        unused_pd;

  // In RSP, next_pc_q is the address of the word being returned.
  fe_predecode u_predecode (
    .word_i       (imem_rdata),
    .pc_i         (next_pc_q),
    .is_branch_o  (pd_is_branch),
    .is_jal_o     (pd_is_jal),
    .pred_taken_o (pd_taken),
    .next_pc_o    (pd_next_pc)
  );

  assign unused_pd = pd_is_branch ^ pd_is_jal;

  // A mispredict report is only trusted when decode is not stalled.
  assign redir    = ex2fe_redirect | (branch_predict_err & ~de_stall);
  assign redir_pc = ex2fe_redirect ? word_align(ex2fe_target)
                                   : word_align(de2fe_branch_target);
  // owed_q carries a pre-reset outstanding read into the first live cycle.
  assign drop_eff = drop_q | owed_q;
  assign rsp_ok   = (state_q == ST_RSP) & imem_rvalid & ~drop_q & ~redir;
  assign to_fe    = rsp_ok & ~de_stall;

  // A delivered response immediately issues its successor for 1 instr/cycle.
  assign imem_req  = rst_n & (((state_q == ST_REQ) & ~drop_eff) |
                              ((state_q == ST_RSP) & to_fe));
  assign imem_addr = (state_q == ST_RSP) ? pd_next_pc : next_pc_q;

  assign fe2de_pc_ffout               = pc_q;
  assign fe2de_ir_ffout               = ir_q;
  assign fe2de_predict_bxxtaken_ffout = pred_q;
  assign fe2de_rv16_ffout             = 1'b0;

  // Request FSM, next fetch address and tracking of responses to discard.
  always_comb begin
    state_d   = state_q;
    next_pc_d = next_pc_q;
    drop_d    = drop_eff;
    case (state_q)
      ST_REQ: begin
        if (drop_eff) begin
          if (imem_rvalid) drop_d = 1'b0;
          if (redir) next_pc_d = redir_pc;
        end else if (redir) begin
          next_pc_d = redir_pc;
          if (imem_gnt) begin
            drop_d  = 1'b1;
            state_d = ST_RSP;
          end
        end else if (imem_gnt) begin
          state_d = ST_RSP;
        end
      end
      ST_RSP: begin
        if (redir) begin
          next_pc_d = redir_pc;
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            next_pc_d = pd_next_pc;
            if (de_stall)      state_d = ST_HOLD;
            else if (imem_gnt) state_d = ST_RSP;
            else               state_d = ST_REQ;
          end
        end
      end
      ST_HOLD: begin
        if (redir) begin
          next_pc_d = redir_pc;
          state_d   = ST_REQ;
        end else if (!de_stall) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // fe2de loading and the one-entry hold buffer used while decode stalls.
  always_comb begin
    pc_d        = pc_q;
    ir_d        = ir_q;
    pred_d      = pred_q;
    hold_v_d    = hold_v_q;
    hold_pc_d   = hold_pc_q;
    hold_ir_d   = hold_ir_q;
    hold_pred_d = hold_pred_q;
    if (redir) begin
      ir_d     = FE_BUBBLE_IR;
      pred_d   = 1'b0;
      hold_v_d = 1'b0;
    end else if (!de_stall) begin
      if (hold_v_q) begin
        pc_d     = hold_pc_q;
        ir_d     = hold_ir_q;
        pred_d   = hold_pred_q;
        hold_v_d = 1'b0;
      end else if (rsp_ok) begin
        pc_d   = next_pc_q;
        ir_d   = imem_rdata;
        pred_d = pd_taken;
      end else begin
        ir_d   = FE_BUBBLE_IR;
        pred_d = 1'b0;
      end
    end else if (rsp_ok) begin
      hold_v_d    = 1'b1;
      hold_pc_d   = next_pc_q;
      hold_ir_d   = imem_rdata;
      hold_pred_d = pd_taken;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_REQ;
      next_pc_q   <= RESET_PC;
      drop_q      <= 1'b0;
      owed_q      <= (owed_q | drop_q | (state_q == ST_RSP)) & ~imem_rvalid;
      hold_v_q    <= 1'b0;
      hold_pc_q   <= RESET_PC;
      hold_ir_q   <= FE_BUBBLE_IR;
      hold_pred_q <= 1'b0;
      pc_q        <= RESET_PC;
      ir_q        <= FE_BUBBLE_IR;
      pred_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_pc_q   <= next_pc_d;
      drop_q      <= drop_d;
      owed_q      <= 1'b0;
      hold_v_q    <= hold_v_d;
      hold_pc_q   <= hold_pc_d;
      hold_ir_q   <= hold_ir_d;
      hold_pred_q <= hold_pred_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      pred_q      <= pred_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch: a latency-randomized instruction memory,
// random stalls and redirects, and a program-stream reference model.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        de_stall, branch_predict_err, ex2fe_redirect;
  logic [31:0] de2fe_branch_target, ex2fe_target;
  logic [31:0] fe2de_pc_ffout, fe2de_ir_ffout;
  logic        fe2de_predict_bxxtaken_ffout, fe2de_rv16_ffout;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk                          (clk),
    .rst_n                        (rst_n),
    .imem_req                     (imem_req),
    .imem_addr                    (imem_addr),
    .imem_gnt                     (imem_gnt),
    .imem_rvalid                  (imem_rvalid),
    .imem_rdata                   (imem_rdata),
    .de_stall                     (de_stall),
    .branch_predict_err           (branch_predict_err),
    .de2fe_branch_target          (de2fe_branch_target),
    .ex2fe_redirect               (ex2fe_redirect),
    .ex2fe_target                 (ex2fe_target),
    .fe2de_pc_ffout               (fe2de_pc_ffout),
    .fe2de_ir_ffout               (fe2de_ir_ffout),
    .fe2de_predict_bxxtaken_ffout (fe2de_predict_bxxtaken_ffout),
    .fe2de_rv16_ffout             (fe2de_rv16_ffout)
  );

  always #5 clk = ~clk;

  int numTests  = 0;
  int numFailed = 0;

  // Program image: word, successor offset and predicted-taken flag per slot.
  logic [31:0] progWord  [0:1023];
  logic [31:0] progDelta [0:1023];
  logic        progPred  [0:1023];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    numTests++;
    if (observed !== expected) begin
      numFailed++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] encB(input logic [31:0] off);
    logic [31:0] r;
    r = $urandom;
    return {off[12], off[10:5], r[24:20], r[19:15], r[14:12], off[4:1], off[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] encJ(input logic [31:0] off);
    return {off[20], off[10:1], off[11], off[19:12], 5'd1, 7'b1101111};
  endfunction

  // Mix of ALU ops, backward/forward branches and JALs; never an all-zero word.
  task automatic buildProgram();
    logic [31:0] tmp, off;
    int          kind;
    for (int i = 0; i < 1024; i++) begin
      tmp  = $urandom;
      kind = $urandom_range(0, 19);
      if (i >= 64 && i < 80) kind = 0;
      if (kind < 12) begin
        progWord[i] = {tmp[31:7], 7'h13};  progDelta[i] = 32'd4; progPred[i] = 1'b0;
      end else if (kind < 15) begin
        off = -(2 * $urandom_range(1, 60));
        progWord[i] = encB(off);           progDelta[i] = off;   progPred[i] = 1'b1;
      end else if (kind < 17) begin
        off = 2 * $urandom_range(1, 60);
        progWord[i] = encB(off);           progDelta[i] = 32'd4; progPred[i] = 1'b0;
      end else begin
        off = 2 * $urandom_range(1, 100);
        if (tmp[0]) off = -off;
        progWord[i] = encJ(off);           progDelta[i] = off;   progPred[i] = 1'b0;
      end
    end
  endtask

  // Memory responder: grants randomly, answers after minLat..maxLat cycles.
  logic        gntRand = 1'b0;
  logic        memPend = 1'b0;
  logic [31:0] memAddr = 32'h0;
  int          memWait = 0;
  int          minLat  = 0;
  int          maxLat  = 0;
  int          gntPct  = 100;

  assign imem_gnt = imem_req & gntRand;

  always @(posedge clk) begin
    if (memPend) begin
      if (memWait == 0) memPend = 1'b0;
      else              memWait--;
    end
    if (imem_req && imem_gnt) begin
      checkOutput("one_outstanding", {31'b0, memPend}, 32'd0);
      checkOutput("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
      memPend = 1'b1;
      memAddr = imem_addr;
      memWait = $urandom_range(minLat, maxLat);
    end
  end

  always @(negedge clk) begin
    imem_rvalid = memPend && (memWait == 0);
    imem_rdata  = imem_rvalid ? progWord[memAddr[11:2]] : $urandom;
    gntRand     = ($urandom_range(0, 99) < gntPct);
  end

  task automatic applyStimulus(input int stallPct, input int bpePct, input int exPct);
    de_stall            = ($urandom_range(0, 99) < stallPct);
    branch_predict_err  = ($urandom_range(0, 99) < bpePct);
    de2fe_branch_target = $urandom;
    ex2fe_redirect      = ($urandom_range(0, 99) < exPct);
    ex2fe_target        = $urandom;
  endtask

  // Reference model: expected next stream PC plus expected fe2de contents.
  logic [31:0] expPc = RESET_PC;
  logic [31:0] mPc   = RESET_PC;
  logic [31:0] mIr   = 32'h0;
  logic        mPred = 1'b0;
  int          delivered    = 0;
  int          sinceRelease = 0;
  bit          fastPhase    = 1'b1;

  always @(posedge clk) begin
    bit          r, st, bpe, ex;
    logic [31:0] bt, et;
    logic [9:0]  idx;
    r  = rst_n;  st = de_stall;  bpe = branch_predict_err;  ex = ex2fe_redirect;
    bt = de2fe_branch_target;    et = ex2fe_target;
    #1;
    checkOutput("rv16", {31'b0, fe2de_rv16_ffout}, 32'd0);
    if (!r) begin
      checkOutput("rst_req",  {31'b0, imem_req}, 32'd0);
      checkOutput("rst_pc",   fe2de_pc_ffout, RESET_PC);
      checkOutput("rst_ir",   fe2de_ir_ffout, 32'd0);
      checkOutput("rst_pred", {31'b0, fe2de_predict_bxxtaken_ffout}, 32'd0);
      expPc = RESET_PC;  mPc = RESET_PC;  mIr = 32'h0;  mPred = 1'b0;
      sinceRelease = 0;
    end else begin
      sinceRelease++;
      if (ex || (bpe && !st)) begin
        checkOutput("redir_pc",   fe2de_pc_ffout, mPc);
        checkOutput("redir_ir",   fe2de_ir_ffout, 32'd0);
        checkOutput("redir_pred", {31'b0, fe2de_predict_bxxtaken_ffout}, 32'd0);
        mIr = 32'h0;  mPred = 1'b0;
        expPc = (ex ? et : bt) & ~32'h3;
      end else if (st) begin
        checkOutput("stall_pc",   fe2de_pc_ffout, mPc);
        checkOutput("stall_ir",   fe2de_ir_ffout, mIr);
        checkOutput("stall_pred", {31'b0, fe2de_predict_bxxtaken_ffout}, {31'b0, mPred});
      end else begin
        if (fastPhase && sinceRelease >= 2)
          checkOutput("throughput", {31'b0, (fe2de_ir_ffout != 32'h0)}, 32'd1);
        if (fe2de_ir_ffout == 32'h0) begin
          checkOutput("bubble_pc",   fe2de_pc_ffout, mPc);
          checkOutput("bubble_pred", {31'b0, fe2de_predict_bxxtaken_ffout}, 32'd0);
          mIr = 32'h0;  mPred = 1'b0;
        end else begin
          idx = expPc[11:2];
          checkOutput("stream_pc",   fe2de_pc_ffout, expPc);
          checkOutput("stream_ir",   fe2de_ir_ffout, progWord[idx]);
          checkOutput("stream_pred", {31'b0, fe2de_predict_bxxtaken_ffout}, {31'b0, progPred[idx]});
          mPc = expPc;  mIr = progWord[idx];  mPred = progPred[idx];
          expPc = (expPc + progDelta[idx]) & ~32'h3;
          delivered++;
        end
      end
    end
  end

  initial begin
    buildProgram();
    rst_n = 1'b0;
    applyStimulus(0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait memory, no stalls or redirects: one instruction per cycle.
    repeat (40) @(negedge clk);
    fastPhase = 1'b0;

    gntPct = 70;  maxLat = 2;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      applyStimulus(20, 8, 4);
    end

    // Reset while a slow read is in flight; its late word must be discarded.
    @(negedge clk);
    applyStimulus(0, 0, 0);
    gntPct = 100;  minLat = 3;  maxLat = 3;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 50 && !memPend; i++) @(negedge clk);
    checkOutput("pend_before_reset", {31'b0, memPend}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    minLat = 0;  maxLat = 2;  gntPct = 70;
    repeat (10) @(negedge clk);

    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      applyStimulus(20, 8, 4);
    end
    @(negedge clk);
    applyStimulus(0, 0, 0);
    repeat (20) @(negedge clk);

    checkOutput("progress", {31'b0, (delivered > 200)}, 32'd1);
    $display("[TB] %0d tests run, %0d failed", numTests, numFailed);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Front-end fetch stage. It owns the PC, issues one-outstanding-request reads to instruction memory, and statically predicts branches and JAL. It drives the fe2de pipeline registers that feed `inst_decode`, and consumes decode's stall and branch-mispredict feedback plus execute's redirect. It is the producer end of the fe2de/de2fe interface.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk` input 1: core clock.
- `rst_n` input 1: reset, synchronous, active-low.
- `imem_req` output 1: read request.
- `imem_addr` output 32: word address; bits [1:0] are always 0.
- `imem_gnt` input 1: request accepted this cycle.
- `imem_rvalid` input 1: read data valid.
- `imem_rdata` input 32: instruction word.
- `de_stall` input 1: decode load-use stall; hold the fe2de registers.
- `branch_predict_err` input 1: decode resolved the branch opposite to the prediction.
- `de2fe_branch_target` input 32: correct continuation PC after a mispredict.
- `ex2fe_redirect` input 1: execute redirect (JALR, trap, mret).
- `ex2fe_target` input 32: redirect PC; bits [1:0] are ignored.
- `fe2de_pc_ffout` output 32: PC of the instruction in decode.
- `fe2de_ir_ffout` output 32: instruction word. A bubble is 32'h0, which decode treats as invalid.
- `fe2de_predict_bxxtaken_ffout` output 1: this branch was predicted taken.
- `fe2de_rv16_ffout` output 1: compressed flag. It is held 0 because this block fetches 32-bit instructions only.

## Operation
- **Reset values** (while `rst_n`=0): pc_ffout=RESET_PC, ir=0, predict=0, rv16=0, imem_req=0, state=REQ, next_pc=RESET_PC, hold buffer empty, drop flag 0.
- **FSM states:**
  - REQ: `imem_req`=1 with `imem_addr`=next_pc. On `imem_gnt`, go to RSP.
  - RSP: wait for `imem_rvalid`. On response, compute next_pc and go to REQ. If the hold buffer becomes full instead, go to HOLD.
  - HOLD: `imem_req`=0 until the buffer drains, then go to REQ.
- **Outstanding requests:** at most one at any time.
- **Predecode of each accepted word:**
  - BRANCH opcode with imm sign bit [31]=1 (backward): predict taken; next_pc = pc + Bimm; predict flag 1.
  - JAL: next_pc = pc + JALimm; predict flag 0. Decode never redirects JAL.
  - Otherwise: next_pc = pc + 4.
  - All additions are 32-bit modulo; wrap-around is not flagged.
- **Delivery:** a response loads {pc, word, predict} into the fe2de registers when `de_stall`=0. If `de_stall`=1 at that point, the response goes into the 1-entry hold buffer. While `de_stall`=1 the fe2de registers keep their value.
- **No instruction available:** with `de_stall`=0 and nothing to deliver, load a bubble (ir=0, predict=0; pc is unchanged).
- **Redirect priority:** `ex2fe_redirect` > `branch_predict_err` > predecode prediction > sequential.
  - `branch_predict_err` is ignored while `de_stall`=1, because decode's operands are stale.
  - `ex2fe_redirect` overrides `de_stall`.
- **On an accepted redirect:**
  - next_pc = target with bits [1:0] cleared.
  - The fe2de registers load a bubble.
  - The hold buffer is cleared.
  - If in RSP, set the drop flag. The pending response is discarded when it arrives and does not advance next_pc.
  - If in REQ without grant, the address switches to the target in the next cycle.
  - If in REQ with grant in the same cycle, set the drop flag.
- **Simultaneous redirect and `imem_rvalid`:** the response is discarded.

## Timing
- **Issue and latency:** `imem_addr` may depend combinationally on `imem_rdata` through predecode. This gives 1 instruction/cycle against a memory with 0-wait grant and 1-cycle rvalid.
- **Sequential fetch:** request granted in cycle n, rvalid in n+1, fe2de registers valid in n+2.
- **Redirect:** redirect in cycle n → bubble in fe2de at n+1; target request at n+1 (or after the dropped response). With 1-cycle memory, the first target instruction is in fe2de at n+3.
- **Reset release:** first request in the first cycle with `rst_n`=1.
- **Reset mid-operation:** any in-flight response after reset is discarded, since the drop flag is set on reset exit when a request was outstanding.

## Structure
- **Shared package / `opcode_define`:** `OPCODE_BRANCH`, `OPCODE_JAL`, `FE_BUBBLE_IR`=32'h0, FSM state encodings.
- **Sub-module `fe_predecode`** (combinational): takes word and pc; returns is_branch, is_jal, pred_taken, next_pc.
- **Top level:** FSM, hold buffer, drop flag, fe2de registers.

## Test plan
- **Reset and sequential fetch:** RESET_PC=0x100, memory returns NOPs (0x00000013) → addresses 0x100, 0x104, 0x108…; first fe2de pc=0x100 two cycles after reset release.
- **Backward branch:** BEQ with offset -8 at 0x200 → next address 0x1F8, predict flag=1. Then `branch_predict_err` with target 0x204 → bubble, then fetch 0x204.
- **JAL:** JAL +0x40 at 0x300 → next address 0x340, predict flag=0, no bubble.
- **Stall hold:** `de_stall` held for 3 cycles while a response arrives → fe2de unchanged, word buffered, no new request. It is delivered the cycle after stall drops, with no instruction lost or duplicated.
- **Redirect in RSP:** `ex2fe_redirect` to 0x8000 while in RSP → the arriving word is dropped, next request is 0x8000, fe2de shows a bubble.
- **Error masked by stall:** `branch_predict_err` asserted together with `de_stall` → ignored; PC stream unchanged.
